// File: rtl/alu_pkg.sv
// Shared ALU opcode, write-back destination and FSM encodings.
// Used by the ALU decoder and the write-back stage.
package alu_pkg;

  localparam int OP_WIDTH = 5;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] WB_DEST_RD = 2'b00;
  localparam logic [1:0] WB_DEST_LO = 2'b01;
  localparam logic [1:0] WB_DEST_HI = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } wb_state_t;

  typedef enum logic [1:0] {
    K_SINGLE,
    K_DOUBLE,
    K_BAD
  } wb_kind_t;

  function automatic wb_kind_t wb_kind(
    input logic [OP_WIDTH-1:0] op
  );
    logic single;
    logic double;
    wb_kind_t k;
    single = (op >= OP_ADD && op <= OP_ORI)
          || op == OP_NEG
          || op == OP_NOT;
    double = op == OP_MUL || op == OP_DIV;
    unique case (1'b1)
      single:  k = K_SINGLE;
      double:  k = K_DOUBLE;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/zreg_pair.sv
// 64-bit Z capture register (high/low halves).
// Synchronous clear has priority over load.
module zreg_pair #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] capture_high,
  input  logic [DATA_W-1:0] capture_low,
  output logic [DATA_W-1:0] high,
  output logic [DATA_W-1:0] low
);

  always_ff @(posedge clock) begin
    if (clear) begin
      high <= '0;
      low  <= '0;
    end else if (load) begin
      high <= capture_high;
      low  <= capture_low;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result write-back stage: captures Z, then issues
// one Rd write or LO/HI writes over a valid/ready port.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = OP_WIDTH
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] z_high_in,
  input  logic [DATA_W-1:0] z_low_in,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [1:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] z_high,
  output logic [DATA_W-1:0] z_low,
  output logic              busy,
  output logic              done,
  output logic              bad_op
);

  wb_state_t       state;
  logic [OP_W-1:0] op_q;
  logic            accept;
  wb_kind_t        kind;

  assign accept = (state == S_IDLE) && start;
  assign kind   = wb_kind(opcode);

  zreg_pair #(
    .DATA_W(DATA_W)
  ) u_zreg (
    .clock       (clock),
    .clear       (clear),
    .load        (accept),
    .capture_high(z_high_in),
    .capture_low (z_low_in),
    .high        (z_high),
    .low         (z_low)
  );

  // Outputs are loaded alongside the next state, so
  // wb_ready never reaches wb_valid combinationally.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= '0;
      bad_op   <= 1'b0;
      wb_valid <= 1'b0;
      wb_dest  <= WB_DEST_RD;
      wb_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= opcode;
            bad_op <= 1'b0;
            busy   <= 1'b1;
            unique case (kind)
              K_SINGLE: begin
                state    <= S_WB_RD;
                wb_valid <= 1'b1;
                wb_dest  <= WB_DEST_RD;
                wb_data  <= z_low_in;
              end
              K_DOUBLE: begin
                state    <= S_WB_LO;
                wb_valid <= 1'b1;
                wb_dest  <= WB_DEST_LO;
                wb_data  <= z_low_in;
              end
              default: begin
                state  <= S_DONE;
                bad_op <= 1'b1;
                done   <= 1'b1;
              end
            endcase
          end
        end
        S_WB_RD, S_WB_HI: begin
          if (wb_ready) begin
            state    <= S_DONE;
            wb_valid <= 1'b0;
            wb_dest  <= WB_DEST_RD;
            wb_data  <= '0;
            done     <= 1'b1;
          end
        end
        S_WB_LO: begin
          if (wb_ready) begin
            state   <= S_WB_HI;
            wb_dest <= WB_DEST_HI;
            wb_data <= z_high;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          wb_valid <= 1'b0;
          wb_dest  <= WB_DEST_RD;
          wb_data  <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
